decode_pipe: RTL and testbench

Parametrised, pipelined decode stage for the WISC core. It holds the 8-entry register file and a per-register scoreboard of in-flight writes, and it stalls fetch on read-after-write hazards. Accepted instructions go into a registered ID/EX slot with a valid/ready handshake toward execute. The slot supports a flush from branch resolution, and write-back forwarding into the read ports can be compiled in or out.

---
 rtl/decode_pipe_if.sv | 43 ++++
 rtl/decode_pipe.sv | 193 +++++++++++++++++++
 tb/tb_decode_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch, write-back, flush and ID/EX handshake bundle for
// decode_pipe. The slave modport is the decode stage; master is its environment.
interface decode_pipe_if #(
  parameter int DATA_W = 16
);
  // fetch side
  logic              if_valid;
  logic              if_ready;
  logic [15:0]       if_instr;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_wr_en;
  logic [1:0]        id_wr_dst;
  // write-back side
  logic              wb_en;
  logic [2:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  // branch resolution
  logic              flush;
  // ID/EX slot toward execute
  logic              ex_valid;
  logic              ex_ready;
  logic [15:0]       ex_instr;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic              ex_wr_en;
  logic [2:0]        ex_wr_reg;
  logic              err;

  modport slave (
    input  if_valid, if_instr, id_uses_rs, id_uses_rt, id_wr_en, id_wr_dst,
    input  wb_en, wb_reg, wb_data, flush, ex_ready,
    output if_ready, ex_valid, ex_instr, ex_rs_data, ex_rt_data,
    output ex_wr_en, ex_wr_reg, err
  );

  modport master (
    output if_valid, if_instr, id_uses_rs, id_uses_rt, id_wr_en, id_wr_dst,
    output wb_en, wb_reg, wb_data, flush, ex_ready,
    input  if_ready, ex_valid, ex_instr, ex_rs_data, ex_rt_data,
    input  ex_wr_en, ex_wr_reg, err
  );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: WISC decode stage. 8-entry register file, per-register count of
// in-flight writes (scoreboard), RAW/saturation stall toward fetch, and a
// registered ID/EX slot with valid/ready toward execute plus flush.
// DATA_W must be >= 16.
// Optional feature macro: DECODE_BYPASS_EN -- forwards the write-back port into
// the read ports and lets the same-cycle retirement clear the hazard.

// One scoreboard counter: net change +inc - dec_wb - dec_fl in a single update,
// clamped at zero with an underflow flag.
module decode_pipe_sb_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec_wb,
  input  logic          dec_fl,
  output logic [CW-1:0] cnt_q,
  output logic          uf
);
  localparam int W1 = CW + 1;

  logic [CW-1:0] cnt_d;
  logic [W1-1:0] up;
  logic [W1-1:0] down;

  // next count; one extra bit so "below zero" is detectable before clamping
  always_comb begin
    up    = {1'b0, cnt_q} + W1'(inc);
    down  = W1'(dec_wb) + W1'(dec_fl);
    cnt_d = cnt_q;
    uf    = 1'b0;
    if (up < down) begin
      cnt_d = '0;
      uf    = 1'b1;
    end else begin
      cnt_d = CW'(up - down);
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

module decode_pipe #(
  parameter int DATA_W       = 16,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic          clk,
  input  logic          rst,
  decode_pipe_if.slave  bus
);
  localparam int CW   = $clog2(MAX_INFLIGHT + 1);
  localparam int NREG = 8;

  typedef struct packed {
    logic [15:0]       instr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wr_en;
    logic [2:0]        wr_reg;
  } slot_t;

  logic [2:0]                   rs, rt, dst;
  logic [NREG-1:0]              wb_hit, inc, fl_dec, uf;
  logic [NREG-1:0][CW-1:0]      cnt_q, cnt_eff;
  logic [NREG-1:0][DATA_W-1:0]  regs_q, regs_d;
  slot_t                        slot_q, slot_d;
  logic                         ex_valid_q, ex_valid_d;
  logic                         err_q, err_d;
  logic                         hazard, ready, accept, flush_dec;
  logic [DATA_W-1:0]            rs_data, rt_data;

  // instruction field decode and destination select
  always_comb begin
    rs = bus.if_instr[10:8];
    rt = bus.if_instr[7:5];
    case (bus.id_wr_dst)
      2'b00:   dst = bus.if_instr[7:5];
      2'b01:   dst = bus.if_instr[10:8];
      2'b10:   dst = bus.if_instr[4:2];
      default: dst = 3'd7;
    endcase
  end

  // per-register write-back match and the count seen by the hazard check
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wb_hit[r] = bus.wb_en && (bus.wb_reg == 3'(r));
`ifdef DECODE_BYPASS_EN
      // a retiring write this cycle no longer blocks its readers; clamp so a
      // stray write-back on an idle register does not read as in-flight
      cnt_eff[r] = (wb_hit[r] && cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : cnt_q[r];
`else
      cnt_eff[r] = cnt_q[r];
`endif
    end
  end

  // register file read ports (combinational in the accept cycle)
  always_comb begin
    rs_data = regs_q[rs];
    rt_data = regs_q[rt];
`ifdef DECODE_BYPASS_EN
    if (bus.wb_en && bus.wb_reg == rs) rs_data = bus.wb_data;
    if (bus.wb_en && bus.wb_reg == rt) rt_data = bus.wb_data;
`endif
  end

  // hazard detection and fetch handshake; ready never looks at if_valid
  always_comb begin
    // the saturation check uses the same effective count so that, with
    // bypass, a retirement frees a slot for a same-cycle new writer
    hazard = (bus.id_uses_rs && cnt_eff[rs] != '0) ||
             (bus.id_uses_rt && cnt_eff[rt] != '0) ||
             (bus.id_wr_en   && cnt_eff[dst] == CW'(MAX_INFLIGHT));
    ready     = !rst && !bus.flush && !hazard && (!ex_valid_q || bus.ex_ready);
    accept    = bus.if_valid && ready;
    // a flushed writer never retires, so give back its scoreboard entry
    flush_dec = bus.flush && ex_valid_q && slot_q.wr_en;
  end

  // scoreboard increment / flush-decrement steering
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc[r]    = accept && bus.id_wr_en && (dst == 3'(r));
      fl_dec[r] = flush_dec && (slot_q.wr_reg == 3'(r));
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_sb
    decode_pipe_sb_cnt #(.CW(CW)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc[g]),
      .dec_wb (wb_hit[g]),
      .dec_fl (fl_dec[g]),
      .cnt_q  (cnt_q[g]),
      .uf     (uf[g])
    );
  end

  // register file write, ID/EX slot next state, underflow pulse
  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en) regs_d[bus.wb_reg] = bus.wb_data;

    slot_d     = slot_q;
    ex_valid_d = ex_valid_q;
    if (bus.flush) begin
      // ex_ready is irrelevant this cycle; ready is low so nothing is accepted
      ex_valid_d = 1'b0;
    end else if (accept) begin
      slot_d.instr   = bus.if_instr;
      slot_d.rs_data = rs_data;
      slot_d.rt_data = rt_data;
      slot_d.wr_en   = bus.id_wr_en;
      slot_d.wr_reg  = dst;
      ex_valid_d     = 1'b1;
    end else if (ex_valid_q && bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end

    err_d = |uf;
  end

  // state registers; reset drops the slot, the file and the error flag at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '0;
      slot_q     <= '0;
      ex_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      slot_q     <= slot_d;
      ex_valid_q <= ex_valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.if_ready   = ready;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_instr   = slot_q.instr;
  assign bus.ex_rs_data = slot_q.rs_data;
  assign bus.ex_rt_data = slot_q.rt_data;
  assign bus.ex_wr_en   = slot_q.wr_en;
  assign bus.ex_wr_reg  = slot_q.wr_reg;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed bench for decode_pipe. Accepted instructions push
// their expected ID/EX contents to a queue; a negedge monitor pops and checks
// them when execute consumes the slot (flushed entries are discarded).
module tb_decode_pipe;
  localparam int DW = 16;

`ifdef DECODE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    logic [15:0]   instr;
    logic [DW-1:0] rs_d;
    logic [DW-1:0] rt_d;
    logic          wr_en;
    logic [2:0]    wr_reg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_pipe_if #(.DATA_W(DW)) bus();
  decode_pipe #(.DATA_W(DW), .MAX_INFLIGHT(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t          sbq[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] mregs [8];
  logic [15:0]   i_a, i_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [15:0] mk(input logic op, input logic [2:0] a, input logic [2:0] b);
    return {1'b0, op, 3'b000, a, b, 5'b00000};
  endfunction

  function automatic logic [2:0] ref_dst(input logic [15:0] ins, input logic [1:0] wd);
    case (wd)
      2'b00:   return ins[7:5];
      2'b01:   return ins[10:8];
      2'b10:   return ins[4:2];
      default: return 3'd7;
    endcase
  endfunction

  task automatic idle();
    bus.if_valid   = 1'b0;
    bus.if_instr   = '0;
    bus.id_uses_rs = 1'b0;
    bus.id_uses_rt = 1'b0;
    bus.id_wr_en   = 1'b0;
    bus.id_wr_dst  = 2'b00;
    bus.wb_en      = 1'b0;
    bus.wb_reg     = '0;
    bus.wb_data    = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic offer(input logic [15:0] ins, input logic urs, input logic urt,
                       input logic we, input logic [1:0] wd);
    bus.if_valid   = 1'b1;
    bus.if_instr   = ins;
    bus.id_uses_rs = urs;
    bus.id_uses_rt = urt;
    bus.id_wr_en   = we;
    bus.id_wr_dst  = wd;
  endtask

  task automatic wb(input logic [2:0] r, input logic [DW-1:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_reg  = r;
    bus.wb_data = d;
  endtask

  // expected slot for the instruction currently offered
  task automatic push_exp(input logic [DW-1:0] rsd, input logic [DW-1:0] rtd);
    exp_t e;
    e.instr  = bus.if_instr;
    e.rs_d   = rsd;
    e.rt_d   = rtd;
    e.wr_en  = bus.id_wr_en;
    e.wr_reg = ref_dst(bus.if_instr, bus.id_wr_dst);
    sbq.push_back(e);
  endtask

  // scoreboard monitor: the slot leaves at the next edge when consumed or flushed
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.ex_valid === 1'b1 && (bus.ex_ready === 1'b1 || bus.flush === 1'b1)) begin
      chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        if (bus.flush !== 1'b1) begin
          chk("sb_instr",  32'(bus.ex_instr),   32'(e.instr));
          chk("sb_rs",     32'(bus.ex_rs_data), 32'(e.rs_d));
          chk("sb_rt",     32'(bus.ex_rt_data), 32'(e.rt_d));
          chk("sb_wr_en",  32'(bus.ex_wr_en),   32'(e.wr_en));
          chk("sb_wr_reg", 32'(bus.ex_wr_reg),  32'(e.wr_reg));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    idle();
    bus.ex_ready = 1'b1;
    rst = 1'b1;

    // reset with fetch presenting an instruction
    offer(mk(1'b0, 3'd3, 3'd0), 1'b1, 1'b0, 1'b0, 2'b00);
    cyc();
    cyc();
    chk("rst_if_ready", 32'(bus.if_ready),   32'd0);
    chk("rst_ex_valid", 32'(bus.ex_valid),   32'd0);
    chk("rst_err",      32'(bus.err),        32'd0);
    chk("rst_ex_instr", 32'(bus.ex_instr),   32'd0);
    chk("rst_ex_rs",    32'(bus.ex_rs_data), 32'd0);
    chk("rst_ex_wrreg", 32'(bus.ex_wr_reg),  32'd0);

    // first instruction after release reads r3 (zero)
    rst = 1'b0;
    settle();
    chk("post_rst_ready", 32'(bus.if_ready), 32'd1);
    push_exp(mregs[3], mregs[0]);
    cyc();
    idle();
    cyc();

    // RAW: producer writes r2, consumer reads r2; write-back three cycles later
    offer(mk(1'b1, 3'd2, 3'd0), 1'b0, 1'b0, 1'b1, 2'b01);
    settle();
    chk("raw_prod_ready", 32'(bus.if_ready), 32'd1);
    push_exp(mregs[2], mregs[0]);
    cyc();
    offer(mk(1'b0, 3'd2, 3'd1), 1'b1, 1'b0, 1'b0, 2'b00);
    settle();
    chk("raw_stall1", 32'(bus.if_ready), 32'd0);
    cyc();
    settle();
    chk("raw_stall2", 32'(bus.if_ready), 32'd0);
    cyc();
    wb(3'd2, 16'h1234);
    settle();
    chk("raw_wb_cycle", 32'(bus.if_ready), 32'(BYP));
    if (BYP) push_exp(16'h1234, mregs[1]);
    cyc();
    mregs[2] = 16'h1234;
    bus.wb_en = 1'b0;
    bus.if_valid = !BYP;
    settle();
    chk("raw_after_wb", 32'(bus.if_ready), 32'd1);
    if (!BYP) push_exp(mregs[2], mregs[1]);
    cyc();
    idle();
    cyc();

    // backpressure: slot held for 4 cycles, then released with a same-cycle accept
    i_a = mk(1'b0, 3'd2, 3'd0);
    i_b = mk(1'b0, 3'd0, 3'd2);
    bus.ex_ready = 1'b0;
    offer(i_a, 1'b1, 1'b0, 1'b0, 2'b00);
    settle();
    chk("bp_accept", 32'(bus.if_ready), 32'd1);
    push_exp(mregs[2], mregs[0]);
    cyc();
    offer(i_b, 1'b0, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp_ready",    32'(bus.if_ready),   32'd0);
      chk("bp_valid",    32'(bus.ex_valid),   32'd1);
      chk("bp_instr",    32'(bus.ex_instr),   32'(i_a));
      chk("bp_rs_data",  32'(bus.ex_rs_data), 32'h1234);
      cyc();
    end
    bus.ex_ready = 1'b1;
    settle();
    chk("bp_release_ready", 32'(bus.if_ready), 32'd1);
    push_exp(mregs[0], mregs[2]);
    cyc();
    idle();
    cyc();

    // saturation: three writers of r7 in flight, the fourth stalls
    offer(mk(1'b0, 3'd0, 3'd0), 1'b0, 1'b0, 1'b1, 2'b11);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("sat_accept", 32'(bus.if_ready), 32'd1);
      push_exp(mregs[0], mregs[0]);
      cyc();
    end
    settle();
    chk("sat_stall1", 32'(bus.if_ready), 32'd0);
    cyc();
    settle();
    chk("sat_stall2", 32'(bus.if_ready), 32'd0);
    cyc();
    wb(3'd7, 16'h0777);
    settle();
    chk("sat_wb_cycle", 32'(bus.if_ready), 32'(BYP));
    if (BYP) push_exp(mregs[0], mregs[0]);
    cyc();
    mregs[7] = 16'h0777;
    bus.wb_en = 1'b0;
    bus.if_valid = !BYP;
    settle();
    chk("sat_after_wb", 32'(bus.if_ready), 32'd1);
    if (!BYP) push_exp(mregs[0], mregs[0]);
    cyc();
    idle();
    cyc();
    chk("sat_no_err", 32'(bus.err), 32'd0);

    // flush colliding with write-back of the flushed destination (r5)
    bus.ex_ready = 1'b0;
    offer(mk(1'b1, 3'd5, 3'd0), 1'b0, 1'b0, 1'b1, 2'b01);
    settle();
    chk("fl_accept", 32'(bus.if_ready), 32'd1);
    push_exp(mregs[5], mregs[0]);
    cyc();
    idle();
    settle();
    chk("fl_slot_valid", 32'(bus.ex_valid),  32'd1);
    chk("fl_slot_reg",   32'(bus.ex_wr_reg), 32'd5);
    bus.flush = 1'b1;
    wb(3'd5, 16'h00AA);
    settle();
    chk("fl_ready_low", 32'(bus.if_ready), 32'd0);
    cyc();
    mregs[5] = 16'h00AA;
    idle();
    bus.ex_ready = 1'b1;
    offer(mk(1'b0, 3'd5, 3'd0), 1'b1, 1'b0, 1'b0, 2'b00);
    settle();
    chk("fl_valid_clr", 32'(bus.ex_valid), 32'd0);
    chk("fl_err_pulse", 32'(bus.err),      32'd1);
    chk("fl_cnt_clamp", 32'(bus.if_ready), 32'd1);
    push_exp(mregs[5], mregs[0]);
    cyc();
    settle();
    chk("fl_err_gone", 32'(bus.err), 32'd0);

    // flush alone with one write to r5 in flight
    offer(mk(1'b1, 3'd5, 3'd0), 1'b0, 1'b0, 1'b1, 2'b01);
    settle();
    chk("fl2_accept", 32'(bus.if_ready), 32'd1);
    push_exp(mregs[5], mregs[0]);
    cyc();
    idle();
    bus.ex_ready = 1'b0;
    bus.flush = 1'b1;
    settle();
    chk("fl2_ready_low", 32'(bus.if_ready), 32'd0);
    cyc();
    idle();
    bus.ex_ready = 1'b1;
    offer(mk(1'b0, 3'd5, 3'd0), 1'b1, 1'b0, 1'b0, 2'b00);
    settle();
    chk("fl2_valid_clr", 32'(bus.ex_valid), 32'd0);
    chk("fl2_no_err",    32'(bus.err),      32'd0);
    chk("fl2_cnt_zero",  32'(bus.if_ready), 32'd1);
    push_exp(mregs[5], mregs[0]);
    cyc();
    settle();
    chk("fl2_no_err2", 32'(bus.err), 32'd0);
    idle();
    cyc();

    // mid-operation reset drops the slot, the scoreboard and the register file
    bus.ex_ready = 1'b0;
    offer(mk(1'b1, 3'd3, 3'd0), 1'b0, 1'b0, 1'b1, 2'b01);
    settle();
    chk("mrst_accept", 32'(bus.if_ready), 32'd1);
    push_exp(mregs[3], mregs[0]);
    cyc();
    idle();
    settle();
    chk("mrst_slot_valid", 32'(bus.ex_valid), 32'd1);
    rst = 1'b1;
    settle();
    chk("mrst_valid", 32'(bus.ex_valid), 32'd0);
    chk("mrst_ready", 32'(bus.if_ready), 32'd0);
    chk("mrst_instr", 32'(bus.ex_instr), 32'd0);
    sbq.delete();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    cyc();
    rst = 1'b0;
    bus.ex_ready = 1'b1;
    offer(mk(1'b0, 3'd3, 3'd2), 1'b1, 1'b1, 1'b1, 2'b11);
    settle();
    chk("mrst_cnt_clear", 32'(bus.if_ready), 32'd1);
    push_exp(mregs[3], mregs[2]);
    cyc();
    idle();
    cyc();
    cyc();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
